// File: rtl/regfile_write_scheduler.sv
// Register-file write-port scheduler: WB has priority, MC results queue in a FIFO and drain into idle WB slots.
// Optional starvation guard enabled by defining RFWS_STARVE_GUARD_EN.
module regfile_write_scheduler #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [4:0]               wb_addr,
  input  logic [31:0]              wb_data,
  input  logic                     mc_valid,
  output logic                     mc_ready,
  input  logic [4:0]               mc_addr,
  input  logic [31:0]              mc_data,
  input  logic                     iss_valid,
  input  logic [4:0]               iss_addr,
  input  logic [4:0]               id_rs,
  input  logic [4:0]               id_rt,
  input  logic [4:0]               id_rd,
  input  logic                     id_valid,
  output logic                     stall,
  output logic                     rf_we,
  output logic [4:0]               rf_addr,
  output logic [31:0]              rf_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]  addr_mem_q [DEPTH];
  logic [4:0]  addr_mem_d [DEPTH];
  logic [31:0] data_mem_q [DEPTH];
  logic [31:0] data_mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   pending_q, pending_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_addr_q, rf_addr_d;
  logic [31:0]   rf_data_q, rf_data_d;

  logic wb_busy, fifo_empty, push, pop, stall_sb;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign wb_busy    = wb_we && (wb_addr != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign mc_ready   = (count_q != (AW+1)'(DEPTH));
  assign push       = mc_valid && mc_ready;
  assign pop        = !wb_busy && !fifo_empty;
  assign head_addr  = addr_mem_q[rd_ptr_q];
  assign head_data  = data_mem_q[rd_ptr_q];

  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = mc_addr;
      data_mem_d[wr_ptr_q] = mc_data;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // A popped $0 entry still advances the FIFO but never asserts the write enable.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (wb_busy) begin
      rf_we_d   = 1'b1;
      rf_addr_d = wb_addr;
      rf_data_d = wb_data;
    end else if (pop) begin
      rf_we_d   = (head_addr != 5'd0);
      rf_addr_d = head_addr;
      rf_data_d = head_data;
    end
  end

  // Clear on pop is applied before set on issue so a same-cycle issue keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[head_addr] = 1'b0;
    if (iss_valid) pending_d[iss_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  assign stall_sb = id_valid && (pending_q[id_rs] | pending_q[id_rt] | pending_q[id_rd]);

`ifdef RFWS_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (wb_busy && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

  assign stall = stall_sb || (starve_q == SW'(STARVE_LIMIT));
`else
  assign stall = stall_sb;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler: expected register-file writes are queued by the stimulus
// and popped by an independent monitor; status outputs are checked inline.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, mc_valid, iss_valid, id_valid;
  logic [4:0]  wb_addr, mc_addr, iss_addr, id_rs, id_rt, id_rd;
  logic [31:0] wb_data, mc_data;
  logic        mc_ready, stall, rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [2:0]  fifo_count;

  int checks = 0;
  int passes = 0;
  logic [36:0] exp_q [$];

  regfile_write_scheduler #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_valid(id_valid),
    .stall(stall), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_we = we; wb_addr = wa; wb_data = wd;
    mc_valid = mv; mc_addr = ma; mc_data = md;
    if (we && wa != 5'd0) exp_q.push_back({wa, wd});
  endtask

  // Monitor: every asserted write enable must match the oldest expected write.
  always @(posedge clk) begin
    #1;
    if (rst && rf_we) begin
      logic [36:0] e;
      if (exp_q.size() == 0) begin
        checkOutput("rf_write_unexpected", {27'd0, rf_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rf_addr", {27'd0, rf_addr}, {27'd0, e[36:32]});
        checkOutput("rf_data", rf_data, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b0;
    iss_valid = 1'b0; iss_addr = '0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset_rf_we", {31'd0, rf_we}, 32'd0);
    checkOutput("reset_rf_addr", {27'd0, rf_addr}, 32'd0);
    checkOutput("reset_rf_data", rf_data, 32'd0);
    checkOutput("reset_mc_ready", {31'd0, mc_ready}, 32'd1);
    checkOutput("reset_fifo_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    rst = 1'b1;

    // WB only, then a WB write to $0 which must be dropped
    @(negedge clk); applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    @(negedge clk); applyStimulus(1'b1, 5'd0, 32'h9999, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checkOutput("wb_zero_dropped_we", {31'd0, rf_we}, 32'd0);
    checkOutput("wb_zero_addr_hold", {27'd0, rf_addr}, 32'd5);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // MC result for r9 waits behind three WB writes
    @(negedge clk); iss_valid = 1'b1; iss_addr = 5'd9;
    @(negedge clk); iss_valid = 1'b0;
    id_valid = 1'b1; id_rs = 5'd9; #1;
    checkOutput("stall_pending_r9", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 5'd3, 32'h100 + i, (i == 0), 5'd9, 32'hCAFE);
      if (i == 1) begin
        #1; checkOutput("mc_buffered_count", {29'd0, fifo_count}, 32'd1);
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    exp_q.push_back({5'd9, 32'hCAFE});
    #1; checkOutput("stall_before_drain", {31'd0, stall}, 32'd1);
    @(negedge clk);
    checkOutput("stall_after_drain", {31'd0, stall}, 32'd0);
    checkOutput("count_after_drain", {29'd0, fifo_count}, 32'd0);
    id_valid = 1'b0; id_rs = 5'd0;

    // Fill the FIFO while WB is busy, reject a fifth result, then drain in order
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 5'd4, 32'h400 + i, 1'b1, 5'(10 + i), 32'hA0 + i);
    end
    @(negedge clk);
    checkOutput("full_count", {29'd0, fifo_count}, 32'd4);
    checkOutput("full_mc_ready", {31'd0, mc_ready}, 32'd0);
    applyStimulus(1'b1, 5'd4, 32'h404, 1'b1, 5'd20, 32'hDEAD);
    @(negedge clk);
    checkOutput("full_count_hold", {29'd0, fifo_count}, 32'd4);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back({5'(10 + i), 32'hA0 + i});
    repeat (2) @(negedge clk);
    checkOutput("drain_mid_count", {29'd0, fifo_count}, 32'd2);
    repeat (2) @(negedge clk);
    checkOutput("drain_end_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("drain_mc_ready", {31'd0, mc_ready}, 32'd1);

    // MC result to $0 is consumed without a write
    @(negedge clk); applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd0, 32'h55);
    @(negedge clk); applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1; checkOutput("zero_entry_count", {29'd0, fifo_count}, 32'd1);
    @(negedge clk);
    checkOutput("zero_entry_popped", {29'd0, fifo_count}, 32'd0);
    checkOutput("zero_entry_no_we", {31'd0, rf_we}, 32'd0);

    // Same-cycle issue and pop on r7 keeps pending set
    @(negedge clk);
    iss_valid = 1'b1; iss_addr = 5'd7;
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h77);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    exp_q.push_back({5'd7, 32'h77});
    @(negedge clk);
    iss_valid = 1'b0;
    id_valid = 1'b1; id_rt = 5'd7; #1;
    checkOutput("r7_set_wins", {31'd0, stall}, 32'd1);
    id_valid = 1'b0; #1;
    checkOutput("stall_needs_id_valid", {31'd0, stall}, 32'd0);
    id_rt = 5'd0;

`ifdef RFWS_STARVE_GUARD_EN
    // Continuous WB traffic starves a buffered result until the guard forces a stall
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 5'd6, 32'h600 + i, (i == 0), 5'd12, 32'hBEEF);
      if (i == 8) begin
        #1; checkOutput("starve_not_yet", {31'd0, stall}, 32'd0);
      end
    end
    @(negedge clk);
    checkOutput("starve_stall", {31'd0, stall}, 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    exp_q.push_back({5'd12, 32'hBEEF});
    @(negedge clk);
    checkOutput("starve_cleared", {31'd0, stall}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Schedules the register file's single write port between two sources: the pipeline writeback stage (WB) and a multi-cycle unit (MC, e.g. mult/div or a load-miss return).
- WB has fixed priority and is never back-pressured. MC results are buffered in a FIFO and drained into idle WB slots.
- A per-register scoreboard tracks outstanding MC destinations and raises a decode-stage stall for RAW/WAW hazards.
- Sits between the WB/MC stages and the register file write port (we, address3, writeData).

Parameters:
- DEPTH, 4, MC result FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 8, consecutive blocked cycles before the starvation guard fires (optional feature only)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- wb_we  in  1  WB write request
- wb_addr  in  5  WB destination register
- wb_data  in  32  WB write data
- mc_valid  in  1  MC result valid
- mc_ready  out  1  FIFO can accept an MC result
- mc_addr  in  5  MC destination register
- mc_data  in  32  MC result data
- iss_valid  in  1  MC operation issued this cycle
- iss_addr  in  5  destination register of the issued MC operation
- id_rs, id_rt, id_rd  in  5 each  decode-stage source/destination registers
- id_valid  in  1  decode holds a real instruction
- stall  out  1  decode must stall
- rf_we  out  1  to register file write enable
- rf_addr  out  5  to register file write address
- rf_data  out  32  to register file write data
- fifo_count  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous): rf_we=0, rf_addr=0, rf_data=0, FIFO empty, fifo_count=0, pending[31:0]=0, mc_ready=1, stall=0.
- rf_we/rf_addr/rf_data are registered with one-cycle latency. The register file writes on the following negedge, so a decode read in the second half of that cycle sees the new value.
- WB slot is "busy" when wb_we=1 and wb_addr!=0. When busy, the next outputs are the WB request.
- When the WB slot is not busy and the FIFO is non-empty, pop the head entry and drive it to the outputs.
- Otherwise the next rf_we=0; rf_addr and rf_data hold their previous values.
- Any write to $0, from WB or popped from the FIFO, is dropped: rf_we stays 0. A popped $0 entry is still consumed.
- Push condition: mc_valid && mc_ready. mc_ready = (fifo_count != DEPTH), computed from registered state. There is no full-FIFO push-through.
- Push and pop in the same cycle: fifo_count is unchanged. Pointers wrap modulo DEPTH.
- pending[r] is set on iss_valid with iss_addr=r, r!=0.
- pending[r] is cleared in the cycle the FIFO entry addressed to r is popped.
- Issue and pop to the same register in the same cycle: set wins, so pending stays 1.
- pending[0] is always 0.
- stall = id_valid && (pending[id_rs] | pending[id_rt] | pending[id_rd]). Combinational from registered pending; no self-clearing.
- Only one outstanding MC operation per register; a WAW on a pending destination is blocked by the stall.
- Reset asserted mid-operation discards FIFO contents and the scoreboard immediately.

Optional Feature:
- Macro: RFWS_STARVE_GUARD_EN.
- Defined:
  - A saturating counter increments each cycle the FIFO is non-empty and the WB slot is busy; it clears on any pop or when the FIFO is empty.
  - When the count reaches STARVE_LIMIT, stall is forced to 1 for the next cycle regardless of id_valid. The pipeline then inserts a bubble, which frees a WB slot.
  - The counter clears on the resulting pop.
- Not defined: no counter; stall follows the scoreboard equation only. MC may starve indefinitely under continuous WB traffic.

Test Plan:
- Reset then idle: rst low for 2 cycles, release -> all outputs 0, mc_ready=1, fifo_count=0.
- WB only: wb_we=1, wb_addr=5, wb_data=0x1234 -> next cycle rf_we=1, rf_addr=5, rf_data=0x1234. wb_addr=0 -> rf_we=0.
- MC drain behind WB: iss_addr=9, then mc_valid with mc_addr=9, mc_data=0xCAFE while wb_we=1 for 3 cycles -> FIFO holds it, pending[9]=1, and stall=1 for id_rs=9. WB idle -> rf_we=1, rf_addr=9, rf_data=0xCAFE; pending[9]=0, stall=0.
- Full FIFO: push DEPTH=4 results with WB busy -> fifo_count=4, mc_ready=0. Fifth mc_valid is not accepted. WB idle -> pops in FIFO order, one per cycle.
- Same-cycle issue and pop on r7 -> pending[7] remains 1.
- With RFWS_STARVE_GUARD_EN: FIFO non-empty and WB busy for 8 cycles -> stall=1 on the next cycle with id_valid=0. WB then idle -> pop occurs and the counter clears.
